// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per enabled clock; done pulses DW enabled edges after accept (1 edge for divide-by-zero).
// No backpressure: start is accepted in IDLE/DONE only, ignored while RUN; EN low freezes every register.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CW-1:0] CNT_INIT = CW'(DW);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [VW:0]   partial;
    logic [DW-1:0] dvd_sr;
    logic [VW-1:0] dvs_r;

    logic [VW:0]   shifted;
    logic [VW+1:0] diff;
    logic          fits;
    logic [VW:0]   next_partial;
    logic [DW-1:0] next_sr;

    // The partial remainder stays below the divisor, so the shifted value fits in VW+1 bits;
    // the extra top bit of diff is the borrow of the trial subtraction.
    always_comb begin
        shifted      = {partial[VW-1:0], dvd_sr[DW-1]};
        diff         = {1'b0, shifted} - {2'b00, dvs_r};
        fits         = ~diff[VW+1];
        next_partial = fits ? diff[VW:0] : shifted;
        next_sr      = {dvd_sr[DW-2:0], fits};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            count     <= '0;
            partial   <= '0;
            dvd_sr    <= '0;
            dvs_r     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (EN) begin
            case (state)
                S_RUN: begin
                    partial <= next_partial;
                    dvd_sr  <= next_sr;
                    count   <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        quotient  <= next_sr;
                        remainder <= next_partial[VW-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                            div_zero  <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_DONE;
                        end else begin
                            dvd_sr   <= dividend;
                            dvs_r    <= divisor;
                            partial  <= '0;
                            count    <= CNT_INIT;
                            busy     <= 1'b1;
                            div_zero <= 1'b0;
                            state    <= S_RUN;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: constant vector table, hand-written corner sequences,
// exhaustive multiply/divide round trip and randomized operations against an arithmetic model.
module tb_seq_divider;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    seq_divider #(.DW(8), .VW(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dones    = 0;
    int last_q   = 0;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
        int lat;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_div(input int a, input int b, output int q, output int r, output int dz);
        if (b == 0) begin
            q = 255; r = 0; dz = 1;
        end else begin
            q = a / b; r = a % b; dz = 0;
        end
    endfunction

    // Issues one start (EN=1 on the accept edge) and waits for done, counting enabled edges.
    task automatic do_op(input int a, input int b, input bit rnd_en,
                         input int eq, input int er, input int edz, input int elat, input string nm);
        int lat;
        int guard;
        dividend = a[7:0];
        divisor  = b[3:0];
        start    = 1'b1;
        EN       = 1'b1;
        step();
        start = 1'b0;
        if (edz == 0) begin
            chk({nm, " busy_after_accept"}, int'(busy), 1);
            chk({nm, " q_held_in_run"}, int'(quotient), last_q);
        end
        lat   = 0;
        guard = 0;
        while (!done && guard < 200) begin
            EN = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            if (EN) lat++;
            guard++;
        end
        EN = 1'b1;
        chk({nm, " done_seen"}, int'(done), 1);
        if (done) dones++;
        if (elat >= 0) chk({nm, " latency"}, lat, elat);
        chk({nm, " quotient"}, int'(quotient), eq);
        chk({nm, " remainder"}, int'(remainder), er);
        chk({nm, " div_zero"}, int'(div_zero), edz);
        last_q = eq;
    endtask

    initial begin
        int q, r, dz, t0, d0, extra, guard, a, b;

        vecs[0] = '{225, 15, 15, 0, 0, 8};
        vecs[1] = '{200,  7, 28, 4, 0, 8};
        vecs[2] = '{ 13,  0, 255, 0, 1, 0};
        vecs[3] = '{  0,  9,  0, 0, 0, 8};
        vecs[4] = '{255,  1, 255, 0, 0, 8};
        vecs[5] = '{255, 15, 17, 0, 0, 8};
        vecs[6] = '{  7,  8,  0, 7, 0, 8};
        vecs[7] = '{100,  6, 16, 4, 0, 8};
        vecs[8] = '{143, 13, 11, 0, 0, 8};
        vecs[9] = '{254, 15, 16, 14, 0, 8};

        // Reset with EN low must still clear everything.
        RST = 1'b1; EN = 1'b0;
        step();
        step();
        RST = 1'b0; EN = 1'b1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset div_zero", int'(div_zero), 0);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, 1'b0, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, $sformatf("vec%0d", i));
            step();
            chk($sformatf("vec%0d done_one_cycle", i), int'(done), 0);
            chk($sformatf("vec%0d busy_idle", i), int'(busy), 0);
            chk($sformatf("vec%0d q_hold", i), int'(quotient), vecs[i].q);
        end

        // Start while EN is low is not accepted.
        EN = 1'b0; start = 1'b1; dividend = 8'd50; divisor = 4'd5;
        step();
        start = 1'b0; EN = 1'b1;
        step();
        chk("en_low_start busy", int'(busy), 0);
        chk("en_low_start q", int'(quotient), last_q);

        // Start inside RUN is ignored.
        dividend = 8'd99; divisor = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        dividend = 8'd50; divisor = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (!done && guard < 50) begin step(); guard++; end
        chk("ignore_start done", int'(done), 1);
        chk("ignore_start q", int'(quotient), 33);
        chk("ignore_start r", int'(remainder), 0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) extra++;
        end
        chk("ignore_start extra_done", extra, 0);
        chk("ignore_start busy", int'(busy), 0);
        last_q = 33;

        // EN stalls mid-RUN and during the done cycle.
        dividend = 8'd250; divisor = 4'd11; start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 3; i++) step();
        EN = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("stall q_held", int'(quotient), 33);
        EN = 1'b1;
        guard = 0;
        while (!done && guard < 50) begin step(); guard++; end
        chk("stall latency", cyc - t0, 13);
        chk("stall q", int'(quotient), 22);
        chk("stall r", int'(remainder), 8);
        EN = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("stall done_held", int'(done), 1);
        EN = 1'b1;
        step();
        chk("stall done_cleared", int'(done), 0);
        last_q = 22;

        // Reset mid-RUN aborts without a done pulse.
        dividend = 8'd100; divisor = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort q", int'(quotient), 0);
        chk("abort r", int'(remainder), 0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) extra++;
        end
        chk("abort no_activity", extra, 0);
        last_q = 0;
        do_op(100, 6, 1'b0, 16, 4, 0, 8, "post_abort");
        step();

        // Reset wins over a simultaneous start.
        RST = 1'b1; start = 1'b1; dividend = 8'd40; divisor = 4'd4;
        step();
        RST = 1'b0; start = 1'b0;
        step();
        chk("rst_start busy", int'(busy), 0);
        chk("rst_start done", int'(done), 0);
        chk("rst_start q", int'(quotient), 0);
        last_q = 0;

        // Round trip over every 4x4 product, back-to-back starts in the done cycle.
        t0 = cyc;
        d0 = dones;
        for (int x = 0; x < 16; x++) begin
            for (int y = 1; y < 16; y++) begin
                ref_div(x * y, y, q, r, dz);
                do_op(x * y, y, 1'b0, q, r, dz, 8, $sformatf("sweep %0d/%0d", x * y, y));
            end
        end
        chk("sweep total_cycles", cyc - t0, 240 * 9);
        chk("sweep done_count", dones - d0, 240);
        step();
        chk("sweep final_done_low", int'(done), 0);

        // Randomized operations with random EN gaps.
        for (int i = 0; i < 150; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            ref_div(a, b, q, r, dz);
            do_op(a, b, 1'b1, q, r, dz, (dz != 0) ? 0 : 8, $sformatf("rand %0d/%0d", a, b));
            if ($urandom_range(0, 1) != 0) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider; the inverse of the pipelined 4x4 multiplier.
- Takes an 8-bit product-width dividend and a 4-bit divisor; returns quotient and remainder.
- Computes one quotient bit per enabled clock.
- Sits beside the multiplier in the arithmetic datapath; round-trip checks divide each multiplier output by its operand.

Parameters:
DW, 8, dividend and quotient width.
VW, 4, divisor and remainder width.

Ports:
CLK  input  1  rising-edge clock.
RST  input  1  synchronous, active-high reset.
EN  input  1  clock enable; when low, all registers hold.
start  input  1  request, sampled on an enabled edge.
dividend  input  DW  numerator, sampled with start.
divisor  input  VW  denominator, sampled with start.
busy  output  1  high while an iteration sequence is running.
done  output  1  single-cycle (enabled-cycle) completion strobe.
quotient  output  DW  result, valid from done until the next accepted start.
remainder  output  VW  result, valid with quotient.
div_zero  output  1  divisor was 0 for the last accepted request.

Behaviour:
- Reset: on a CLK edge with RST=1 (regardless of EN):
  - state=IDLE.
  - busy=0, done=0, div_zero=0, quotient=0, remainder=0.
  - Internal counter and partial-remainder registers cleared.
- States: IDLE, RUN, DONE.
- Qualification: all transitions occur only on edges with EN=1. With EN=0 every register, including done, holds its value.
- Start acceptance:
  - start=1 is accepted in IDLE or DONE.
  - start in RUN is ignored; the operation in flight is unaffected.
- Accept edge, divisor != 0:
  - Latch dividend into the shift register and divisor into the divisor register.
  - Clear the partial remainder (VW+1 bits) and set count=DW.
  - busy=1, done=0, div_zero=0, state goes to RUN.
- Accept edge, divisor == 0:
  - quotient=all ones (255), remainder=0, div_zero=1.
  - done=1, busy=0, state goes to DONE. Latency is 1 enabled edge.
- RUN, each enabled edge:
  - Shift {partial, dividend_sr} left by 1.
  - trial = partial - {0,divisor}.
  - If trial is non-negative, partial=trial and the shifted-in quotient bit is 1; otherwise the bit is 0.
  - count decrements.
- RUN, edge where count reaches 0 (the DW-th iteration edge):
  - quotient and remainder are registered from the final values; the remainder is always < divisor and fits in VW bits.
  - busy=0, done=1, state goes to DONE.
- Latency: done is visible after the DW-th enabled edge following the accept edge (8 enabled cycles at default).
- DONE:
  - done is high for exactly one enabled cycle.
  - Next enabled edge: go to IDLE with done=0, or accept a new start (back-to-back, zero bubble).
  - quotient, remainder and div_zero hold until the next accept edge.
- Outputs never change in RUN; quotient and remainder update only on completion edges.
- Arithmetic: unsigned only. dividend=0 gives q=0, r=0 after the full DW cycles. divisor=1 gives q=dividend, r=0.
- RST mid-RUN aborts the operation: no done pulse, all outputs return to reset values next cycle.
- Simultaneous RST and start: RST wins; start is dropped.

Test Plan:
1. RST 2 cycles, then start with dividend=225, divisor=15 -> busy for 8 cycles, done pulses once, q=15, r=0, div_zero=0.
2. dividend=200, divisor=7 -> q=28, r=4. dividend=13, divisor=0 -> done on the next edge, q=255, r=0, div_zero=1. dividend=0, divisor=9 -> q=0, r=0 after 8 cycles.
3. Round-trip sweep: for a,b in 0..15 with b != 0, dividend=a*b, divisor=b, back-to-back starts issued in the done cycle -> every result q=a, r=0, no idle cycles between operations, done count=240.
4. start pulsed with dividend=99, divisor=3; another start (dividend=50, divisor=5) issued in cycle 3 of RUN -> ignored, result q=33, r=0, only one done.
5. dividend=250, divisor=11 with EN held low for 5 cycles mid-RUN -> done appears 13 cycles after accept, q=22, r=8; with EN low during done, done stays high until EN returns.
6. RST asserted in cycle 4 of RUN (dividend=100, divisor=6) -> next cycle busy=0, done=0, q=0, r=0, no done pulse afterwards; a new start then yields q=16, r=4.
